mmio_regfile: RTL and testbench

Parametrised processor register file with a hardwired zero register, two CPU read ports and one write port. Adds a third read-only debug/display port, a synchronised external-input register, and a sticky rising-edge event register with write-1-to-clear. Optional write-to-read bypass. It replaces the fixed 32x32 register file in the game processor and feeds the VGA/audio logic (ball, paddle and note registers) through the display port instead of hard taps.

---
 rtl/mmio_regfile.sv | 85 ++++++++
 tb/tb_mmio_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_regfile.sv
// Processor register file with hardwired zero, two CPU read ports, a debug/display read port,
// a synchronised external-input register and a sticky rising-edge event register (write-1-to-clear).
module mmio_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int IN_REG  = 29,
  parameter int EVT_REG = 28,
  parameter int BYPASS  = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic [ADDR_W-1:0] ctrl_readRegC,
  output logic [DATA_W-1:0] data_readRegC,
  input  logic [DATA_W-1:0] external_inputs,
  output logic [DATA_W-1:0] in_out,
  output logic [DATA_W-1:0] evt_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_REG);
  localparam logic [ADDR_W-1:0] EVT_A = ADDR_W'(EVT_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] sync1_q, sync1_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] evt_q, evt_d;
  logic [DATA_W-1:0] rise, clr;
  logic              wr_store;

  function automatic logic is_storage(input logic [ADDR_W-1:0] a);
    return (a != '0) && (a != IN_A) && (a != EVT_A);
  endfunction

  // Zero, input and event registers are never forwarded; only storage registers see bypass.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (a == '0)                                          return '0;
    if (a == IN_A)                                        return in_q;
    if (a == EVT_A)                                       return evt_q;
    if ((BYPASS != 0) && wr_store && (a == ctrl_writeReg)) return data_writeReg;
    return regs_q[a];
  endfunction

  always_comb begin
    wr_store = ctrl_writeEnable && is_storage(ctrl_writeReg);
    regs_d   = regs_q;
    if (wr_store) regs_d[ctrl_writeReg] = data_writeReg;
    sync1_d = external_inputs;
    in_d    = sync1_q;
    rise    = sync1_q & ~in_q;
    clr     = (ctrl_writeEnable && (ctrl_writeReg == EVT_A)) ? data_writeReg : '0;
    // Set wins over clear on the same bit in the same cycle.
    evt_d   = (evt_q & ~clr) | rise;
  end

  always_comb begin
    data_readRegA = read_port(ctrl_readRegA);
    data_readRegB = read_port(ctrl_readRegB);
    data_readRegC = read_port(ctrl_readRegC);
    in_out        = in_q;
    evt_out       = evt_q;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      sync1_q <= '0;
      in_q    <= '0;
      evt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      sync1_q <= sync1_d;
      in_q    <= in_d;
      evt_q   <= evt_d;
    end
  end

endmodule

// File: tb/tb_mmio_regfile.sv
// Bench for mmio_regfile: directed steps then random traffic, one instance with bypass and one without,
// both checked every cycle against a register-level reference model.
module tb_mmio_regfile;

  localparam int IN  = 29;
  localparam int EV  = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wr, ra, rb, rc;
  logic [31:0] wd, ext;
  logic [31:0] a1, b1, c1, in1, ev1;
  logic [31:0] a0, b0, c0, in0, ev0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] mem [32];
  logic [31:0] m_sync1, m_in, m_evt;
  bit          mdl_valid = 0;

  always #5 clk = ~clk;

  mmio_regfile #(.BYPASS(1)) dut_b (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(a1), .data_readRegB(b1), .ctrl_readRegC(rc), .data_readRegC(c1),
    .external_inputs(ext), .in_out(in1), .evt_out(ev1)
  );

  mmio_regfile #(.BYPASS(0)) dut_n (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(a0), .data_readRegB(b0), .ctrl_readRegC(rc), .data_readRegC(c0),
    .external_inputs(ext), .in_out(in0), .evt_out(ev0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    int ai = int'(a);
    if (ai == 0)   return 32'h0;
    if (ai == IN)  return m_in;
    if (ai == EV)  return m_evt;
    if (byp && we && (a == wr)) return wd;
    return mem[ai];
  endfunction

  // Check current combinational outputs against the model, clock one edge, advance the model.
  task automatic tick();
    logic [31:0] nevt;
    int          wi;
    #1;
    if (mdl_valid) begin
      chk("rdA_byp",  a1,  exp_read(ra, 1));
      chk("rdB_byp",  b1,  exp_read(rb, 1));
      chk("rdC_byp",  c1,  exp_read(rc, 1));
      chk("rdA_nobp", a0,  exp_read(ra, 0));
      chk("rdB_nobp", b0,  exp_read(rb, 0));
      chk("rdC_nobp", c0,  exp_read(rc, 0));
      chk("in_out",   in1, m_in);
      chk("evt_out",  ev1, m_evt);
      chk("in_out_n", in0, m_in);
      chk("evt_out_n", ev0, m_evt);
    end
    @(posedge clk);
    wi = int'(wr);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      m_sync1 = 0; m_in = 0; m_evt = 0;
      mdl_valid = 1;
    end else begin
      nevt = (m_evt & ~((we && wi == EV) ? wd : 32'h0)) | (m_sync1 & ~m_in);
      m_evt   = nevt;
      m_in    = m_sync1;
      m_sync1 = ext;
      if (we && wi != 0 && wi != IN && wi != EV) mem[wi] = wd;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; we = 1; wr = 5'd9; wd = 32'hAA; ra = 0; rb = 0; rc = 0; ext = 32'h0;
    @(negedge clk);
    tick();
    rst = 0; we = 0; ra = 5'd9; rb = 5'd29; rc = 5'd28;
    #1;
    chk("rst_reg9", a1, 32'h0);
    chk("rst_in",   in1, 32'h0);
    chk("rst_evt",  ev1, 32'h0);
    tick();

    // Write and read back on all ports; bypass vs. registered view.
    we = 1; wr = 5'd5; wd = 32'hDEADBEEF; ra = 5'd5; rb = 5'd5; rc = 5'd5;
    #1;
    chk("byp_same_cycle", a1, 32'hDEADBEEF);
    chk("nobyp_old",      a0, 32'h0);
    tick();
    we = 0;
    #1;
    chk("wr5_A", a0, 32'hDEADBEEF);
    chk("wr5_B", b0, 32'hDEADBEEF);
    chk("wr5_C", c1, 32'hDEADBEEF);
    tick();

    we = 1; wr = 5'd0; wd = 32'hFFFFFFFF; ra = 5'd0;
    #1;
    chk("r0_no_bypass", a1, 32'h0);
    tick();
    we = 0;
    #1;
    chk("r0_zero", a0, 32'h0);
    tick();

    we = 1; wr = 5'd7; wd = 32'h1234; ra = 5'd7;
    #1;
    chk("byp_r7",   a1, 32'h1234);
    chk("nobyp_r7", a0, 32'h0);
    tick();
    we = 0;
    #1;
    chk("r7_after", a0, 32'h1234);
    tick();

    // Input synchroniser latency and write protection.
    ext = 32'h5;
    tick();
    #1 chk("sync_k",  in1, 32'h0);
    tick();
    #1 chk("sync_k1", in1, 32'h5);
    we = 1; wr = 5'd29; wd = 32'hFFFF; ra = 5'd29;
    #1 chk("in_no_byp", a1, 32'h5);
    tick();
    we = 0;
    #1 chk("in_wprot", in1, 32'h5);
    we = 1; wr = 5'd28; wd = 32'h5;
    tick();
    we = 0;
    #1 chk("evt_clr5", ev1, 32'h0);

    // Event bit 3: set, sticky, clear, held-high no re-set.
    ext = 32'h0; tick(); tick();
    ext = 32'h8; tick();
    #1 chk("evt_pre", ev1, 32'h0);
    tick();
    #1 chk("evt_set3", ev1, 32'h8);
    ext = 32'h0; tick(); tick();
    #1 chk("evt_sticky", ev1, 32'h8);
    we = 1; wr = 5'd28; wd = 32'h8; tick(); we = 0;
    #1 chk("evt_w1c", ev1, 32'h0);
    ext = 32'h8; tick(); tick();
    we = 1; wr = 5'd28; wd = 32'h8; tick(); we = 0;
    tick(); tick();
    #1 chk("evt_held_no_reset", ev1, 32'h0);

    // Set beats clear on bit 0.
    ext = 32'h9; tick();
    we = 1; wr = 5'd28; wd = 32'h1; tick(); we = 0;
    #1 chk("evt_set_wins", ev1 & 32'h1, 32'h1);

    // Reset dominates write and pending rise; synchroniser flushed.
    ext = 32'h0; tick(); tick();
    ext = 32'h2; tick();
    rst = 1; we = 1; wr = 5'd9; wd = 32'hAA; tick();
    rst = 0; we = 0; ra = 5'd9; rb = 5'd28; rc = 5'd29;
    #1;
    chk("rstp_r9",  a1, 32'h0);
    chk("rstp_in",  in1, 32'h0);
    chk("rstp_evt", ev1, 32'h0);
    tick();
    #1 chk("post_rst_evt1", ev1, 32'h0);
    tick();
    #1 chk("post_rst_evt2", ev1, 32'h2);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = $urandom_range(0, 1);
      wr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) wr = ($urandom_range(0, 1) != 0) ? 5'd28 : 5'd29;
      wd  = $urandom;
      ra  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rb  = 5'($urandom_range(0, 31));
      rc  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) ext = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
